datapath_hs: RTL and testbench



---
 rtl/datapath_hs.sv | 222 ++++++++++++++++++++++
 tb/tb_datapath_hs.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_hs.sv
// Parametrised multicycle datapath: PC/IR/A/B/F/MDR, register file, ALU, registered
// flags and a valid/ready memory port driven by a small IDLE/RD/WR bus FSM.
module datapath_hs #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              en_b,
  input  logic              en_f,
  input  logic              en_pc,
  input  logic [3:0]        alu_op,
  input  logic              s_addr,
  input  logic              s_regfile_din,
  input  logic              s_regfile_rw,
  input  logic              we_regfile,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              rd_to_ir,
  output logic [3:0]        opcode,
  output logic              zero,
  output logic              neg,
  output logic              carry,
  output logic              mem_busy,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        wait_cnt
);

  localparam int NREG = 2 ** REG_AW;
  localparam int IMM_W = DATA_W - 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  // Architectural registers
  logic [DATA_W-1:0] pc_q, ir_q, a_q, b_q, f_q, mdr_q;
  logic              zero_q, neg_q, carry_q;
  logic [DATA_W-1:0] rf_q [NREG];

  // Bus FSM state and transaction latches
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              to_ir_q, to_ir_d;
  logic [7:0]        wait_q, wait_d;

  // IR field decode
  logic [REG_AW-1:0] rw_idx, ra_idx, rb_idx;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_sext, imm_zext;

  assign opcode   = ir_q[DATA_W-1 -: 4];
  assign rw_idx   = ir_q[DATA_W-5 -: REG_AW];
  assign ra_idx   = ir_q[DATA_W-5-REG_AW -: REG_AW];
  assign rb_idx   = ir_q[DATA_W-5-2*REG_AW -: REG_AW];
  assign imm      = ir_q[IMM_W-1:0];
  assign imm_sext = {{4{imm[IMM_W-1]}}, imm};
  assign imm_zext = {4'b0000, imm};

  // Register file: write index and data selection, per-entry write strobes
  logic [REG_AW-1:0] wi;
  logic [DATA_W-1:0] rf_din;
  logic [NREG-1:0]   wr_sel;
  logic [DATA_W-1:0] rf_ra, rf_rb;

  assign wi     = s_regfile_rw ? {REG_AW{1'b1}} : rw_idx;
  assign rf_din = s_regfile_din ? mdr_q : f_q;
  assign rf_ra  = rf_q[ra_idx];
  assign rf_rb  = rf_q[rb_idx];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_wsel
      assign wr_sel[gi] = we_regfile && (wi == REG_AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_sel[i]) rf_q[i] <= rf_din;
      end
    end
  end

  // ALU: extended-width sums give carry-out; subtraction carry is NOT borrow
  logic [DATA_W:0]   sum_ab, diff_ab, pc_inc, pc_imm;
  logic [DATA_W-1:0] alu_out;
  logic              alu_c;

  assign sum_ab  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ab = {1'b0, a_q} + {1'b0, ~b_q} + (DATA_W+1)'(1);
  assign pc_inc  = {1'b0, pc_q} + (DATA_W+1)'(1);
  assign pc_imm  = {1'b0, pc_q} + {1'b0, imm_sext};

  always_comb begin
    alu_out = '0;
    alu_c   = 1'b0;
    case (alu_op)
      4'd0:  {alu_c, alu_out} = sum_ab;
      4'd1:  {alu_c, alu_out} = diff_ab;
      4'd2:  alu_out = a_q & b_q;
      4'd3:  alu_out = a_q | b_q;
      4'd4:  alu_out = a_q ^ b_q;
      4'd5:  alu_out = ~a_q;
      4'd6: begin
        alu_out = {a_q[DATA_W-2:0], 1'b0};
        alu_c   = a_q[DATA_W-1];
      end
      4'd7: begin
        alu_out = {1'b0, a_q[DATA_W-1:1]};
        alu_c   = a_q[0];
      end
      4'd8:  alu_out = a_q;
      4'd9:  {alu_c, alu_out} = pc_inc;
      4'd10: {alu_c, alu_out} = pc_imm;
      4'd11: alu_out = imm_zext;
      default: begin
        alu_out = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // Bus FSM next-state; commands are only looked at in IDLE and read wins a tie
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    to_ir_d = to_ir_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (mem_rd) begin
          addr_d  = s_addr ? f_q : pc_q;
          to_ir_d = rd_to_ir;
          wait_d  = 8'd0;
          state_d = S_RD;
        end else if (mem_wr) begin
          addr_d  = s_addr ? f_q : pc_q;
          wdata_d = a_q;
          wait_d  = 8'd0;
          state_d = S_WR;
        end
      end
      S_RD, S_WR: begin
        if (mem_ready) begin
          state_d = S_IDLE;
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      to_ir_q <= 1'b0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      to_ir_q <= to_ir_d;
      wait_q  <= wait_d;
    end
  end

  logic rd_done;
  assign rd_done = (state_q == S_RD) && mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      mdr_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      if (en_a)  a_q  <= rf_ra;
      if (en_b)  b_q  <= rf_rb;
      if (en_pc) pc_q <= alu_out;
      if (en_f) begin
        f_q     <= alu_out;
        zero_q  <= (alu_out == '0);
        neg_q   <= alu_out[DATA_W-1];
        carry_q <= alu_c;
      end
      if (rd_done) begin
        if (to_ir_q) ir_q  <= mem_rdata;
        else         mdr_q <= mem_rdata;
      end
    end
  end

  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign mem_valid = (state_q != S_IDLE);
  assign mem_busy  = (state_q != S_IDLE);
  assign mem_we    = (state_q == S_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wait_cnt  = wait_q;

endmodule

// File: tb/tb_datapath_hs.sv
// Directed bench for datapath_hs: memory transactions are scored against an
// expectation queue filled when each command is issued.
module tb_datapath_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b, en_f, en_pc;
  logic [3:0]  alu_op;
  logic        s_addr, s_regfile_din, s_regfile_rw, we_regfile;
  logic        mem_rd, mem_wr, rd_to_ir;
  logic [3:0]  opcode;
  logic        zero, neg, carry, mem_busy;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_we, mem_valid, mem_ready;
  logic [15:0] mem_rdata;
  logic [7:0]  wait_cnt;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t sb[$];

  datapath_hs #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .en_b(en_b), .en_f(en_f), .en_pc(en_pc),
    .alu_op(alu_op), .s_addr(s_addr),
    .s_regfile_din(s_regfile_din), .s_regfile_rw(s_regfile_rw),
    .we_regfile(we_regfile), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .rd_to_ir(rd_to_ir), .opcode(opcode),
    .zero(zero), .neg(neg), .carry(carry), .mem_busy(mem_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic rd_cmd(input logic to_ir, input logic sel, input logic [15:0] exp_addr);
    txn_t t;
    t.we = 1'b0; t.addr = exp_addr; t.wdata = 16'h0000;
    sb.push_back(t);
    mem_rd = 1'b1; rd_to_ir = to_ir; s_addr = sel;
    tick();
    mem_rd = 1'b0;
    chk("busy_after_rd", mem_busy, 1'b1);
  endtask

  task automatic wr_cmd(input logic sel, input logic [15:0] exp_addr, input logic [15:0] exp_wdata);
    txn_t t;
    t.we = 1'b1; t.addr = exp_addr; t.wdata = exp_wdata;
    sb.push_back(t);
    mem_wr = 1'b1; s_addr = sel;
    tick();
    mem_wr = 1'b0;
    chk("busy_after_wr", mem_busy, 1'b1);
  endtask

  // Memory side: hold ready low for 'waits' cycles, then complete the transfer
  task automatic serve(input int waits, input logic [15:0] rdata, input bit poke);
    txn_t t;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    t = sb.pop_front();
    for (int i = 0; i < waits; i++) begin
      chk("valid_wait", mem_valid, 1'b1);
      chk("addr_stable", mem_addr, t.addr);
      mem_ready = 1'b0;
      mem_wr = poke && (i == 0);
      tick();
      mem_wr = 1'b0;
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    chk("valid_xfer", mem_valid, 1'b1);
    chk("we_xfer", mem_we, t.we);
    chk("addr_xfer", mem_addr, t.addr);
    if (t.we) chk("wdata_xfer", mem_wdata, t.wdata);
    tick();
    mem_ready = 1'b0;
    chk("busy_done", mem_busy, 1'b0);
    chk("wait_cnt", wait_cnt, 8'(waits));
  endtask

  task automatic rf_write(input logic from_mdr, input logic link);
    s_regfile_din = from_mdr; s_regfile_rw = link; we_regfile = 1'b1;
    tick();
    we_regfile = 1'b0; s_regfile_rw = 1'b0; s_regfile_din = 1'b0;
  endtask

  task automatic load_ab();
    en_a = 1'b1; en_b = 1'b1;
    tick();
    en_a = 1'b0; en_b = 1'b0;
  endtask

  task automatic alu_f(input logic [3:0] op);
    alu_op = op; en_f = 1'b1;
    tick();
    en_f = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {en_a, en_b, en_f, en_pc} = 4'b0;
    alu_op = 4'd0; s_addr = 1'b0; s_regfile_din = 1'b0; s_regfile_rw = 1'b0;
    we_regfile = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; rd_to_ir = 1'b0;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", mem_valid, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_busy", mem_busy, 1'b0);
    chk("rst_opcode", opcode, 4'd0);
    chk("rst_flags", {zero, neg, carry}, 3'b000);
    chk("rst_wait", wait_cnt, 8'd0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 16'h0000);

    // Reset in the middle of a stalled fetch
    mem_rd = 1'b1; rd_to_ir = 1'b1; s_addr = 1'b0; mem_rdata = 16'hFFFF;
    tick();
    mem_rd = 1'b0;
    chk("mid_busy", mem_busy, 1'b1);
    repeat (2) tick();
    chk("mid_wait", wait_cnt, 8'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", mem_valid, 1'b0);
    chk("async_busy", mem_busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_opcode", opcode, 4'd0);
    chk("abort_wait", wait_cnt, 8'd0);
    chk("abort_valid", mem_valid, 1'b0);

    // Fetch with zero wait, then with three wait states
    rd_cmd(1'b1, 1'b0, 16'h0000);
    serve(0, 16'h1234, 1'b0);
    chk("fetch0_opcode", opcode, 4'd1);
    rd_cmd(1'b1, 1'b0, 16'h0000);
    serve(3, 16'h211F, 1'b0);
    chk("fetch3_opcode", opcode, 4'd2);

    // rf[1]=FFFF via rw, rf[15]=1 via link; A=FFFF, B=1, add
    rd_cmd(1'b0, 1'b0, 16'h0000);
    serve(0, 16'hFFFF, 1'b0);
    rf_write(1'b1, 1'b0);
    rd_cmd(1'b0, 1'b0, 16'h0000);
    serve(0, 16'h0001, 1'b0);
    rf_write(1'b1, 1'b1);
    load_ab();
    alu_f(4'd0);
    chk("add_flags", {zero, neg, carry}, 3'b101);
    rd_cmd(1'b0, 1'b1, 16'h0000);
    serve(0, 16'h0000, 1'b0);

    // A=rf[0]=0, B=rf[15]=1, subtract
    rd_cmd(1'b1, 1'b0, 16'h0000);
    serve(0, 16'h200F, 1'b0);
    load_ab();
    alu_f(4'd1);
    chk("sub_flags", {zero, neg, carry}, 3'b010);
    rd_cmd(1'b0, 1'b1, 16'hFFFF);
    serve(1, 16'h0000, 1'b0);

    // PC=PC+1, then fetch from the new PC
    alu_op = 4'd9; en_pc = 1'b1;
    tick();
    en_pc = 1'b0;
    rd_cmd(1'b1, 1'b0, 16'h0001);
    serve(0, 16'h3400, 1'b0);
    chk("pc_opcode", opcode, 4'd3);

    // rf[4]=BEEF, A=rf[4], F=zext imm 0x040, store A at F
    rd_cmd(1'b0, 1'b0, 16'h0001);
    serve(0, 16'hBEEF, 1'b0);
    rf_write(1'b1, 1'b0);
    rd_cmd(1'b1, 1'b0, 16'h0001);
    serve(0, 16'h3040, 1'b0);
    load_ab();
    alu_f(4'd11);
    chk("imm_flags", {zero, neg, carry}, 3'b000);
    wr_cmd(1'b1, 16'h0040, 16'hBEEF);
    serve(2, 16'h0000, 1'b0);

    // Load back into the link register and read it out through B
    rd_cmd(1'b0, 1'b1, 16'h0040);
    serve(1, 16'hBEEF, 1'b0);
    rf_write(1'b1, 1'b1);
    rd_cmd(1'b1, 1'b0, 16'h0001);
    serve(0, 16'h300F, 1'b0);
    load_ab();
    alu_f(4'd0);
    chk("link_flags", {zero, neg, carry}, 3'b010);

    // Simultaneous read and write: the read wins
    sb.push_back('{we: 1'b0, addr: 16'hBEEF, wdata: 16'h0000});
    mem_rd = 1'b1; mem_wr = 1'b1; rd_to_ir = 1'b0; s_addr = 1'b1;
    tick();
    mem_rd = 1'b0; mem_wr = 1'b0;
    chk("tie_we", mem_we, 1'b0);
    serve(0, 16'h1111, 1'b0);

    // Command while busy is dropped
    rd_cmd(1'b0, 1'b0, 16'h0001);
    serve(2, 16'h5555, 1'b1);
    tick();
    chk("no_second_txn", mem_busy, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // F and PC moving during a transaction leave mem_addr alone
    rd_cmd(1'b0, 1'b1, 16'hBEEF);
    alu_op = 4'd9; en_pc = 1'b1; en_f = 1'b1;
    serve(2, 16'h0000, 1'b0);
    en_pc = 1'b0; en_f = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
